// File: rtl/counter_updown_mod_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod_if
// Desc     : Control/status bundle between a counter user and the counter.
// Revision : 1.0
// ============================================================================
interface counter_updown_mod_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             sat;

    modport master (
        output en, up_dn, load, load_val,
        input  count, tc, wrap, sat
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, tc, wrap, sat
    );
endinterface
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod
// Desc     : Parametrised up/down modulo counter with load, wrap/saturate mode
//            and terminal-count / boundary-event flags for cascading.
// Revision : 1.0
// ============================================================================
module counter_updown_mod #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_updown_mod_if.slave  bus
);
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 64'd1);
    localparam bit               c_SAT = (SATURATE != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_sat;

    logic             w_at_max;
    logic             w_at_min;
    logic             w_at_edge;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max       = (r_count == c_MAX);
    assign w_at_min       = (r_count == '0);
    assign w_at_edge      = bus.up_dn ? w_at_max : w_at_min;
    assign w_load_clamped = (bus.load_val > c_MAX) ? c_MAX : bus.load_val;

    // The increment/decrement path is only taken away from the boundary, so a
    // full 2**WIDTH modulus never relies on native overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
            if (bus.load) begin
                r_count <= w_load_clamped;
            end else if (bus.en) begin
                if (!w_at_edge) begin
                    r_count <= bus.up_dn ? (r_count + 1'b1) : (r_count - 1'b1);
                end else if (c_SAT) begin
                    r_sat <= 1'b1;
                end else begin
                    r_count <= bus.up_dn ? '0 : c_MAX;
                    r_wrap  <= 1'b1;
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = bus.en & w_at_edge;
    assign bus.wrap  = r_wrap;
    assign bus.sat   = r_sat;
endmodule
`default_nettype wire
